// File: rtl/bram_read_streamer.sv
// Purpose : sweeps a (base, count) range of one BRAM read port and streams it out as valid/ready.
// Latency : command accepted at edge k -> first out_valid after edge k+2, then 1 word/cycle.
// Backpressure: full; reads are issued only when the skid FIFO has a free slot for them.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake; cmd_base = first address, cmd_count = words (0..2**ADDR)
//   bram_addr / bram_dout      BRAM read port; dout is valid one cycle after addr
//   out_valid/out_ready        output stream handshake; out_data = word, out_last = final word
//   done                       one-cycle pulse after the command is fully delivered
module bram_read_streamer #(
  parameter int DATA       = 72,
  parameter int ADDR       = 10,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [ADDR-1:0] cmd_base,
  input  logic [ADDR:0]   cmd_count,
  output logic [ADDR-1:0] bram_addr,
  input  logic [DATA-1:0] bram_dout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DATA-1:0] out_data,
  output logic            out_last,
  output logic            done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // One extra bit so occupancy plus the in-flight read never overflows.
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic [ADDR:0]   remain_q, remain_d;
  logic            pending_q, pending_d;
  logic            last_pend_q, last_pend_d;
  logic            done_q, done_d;

  // Skid FIFO absorbing the reads already in flight when the consumer stalls.
  logic [DATA-1:0] fifo_dat_q  [FIFO_DEPTH];
  logic            fifo_last_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   fifo_cnt_q;

  logic          push, pop, issue;
  logic [CW-1:0] occ;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign out_valid = (fifo_cnt_q != '0);
  assign out_data  = fifo_dat_q[rd_ptr_q];
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign cmd_ready = (state_q == S_IDLE);
  assign bram_addr = addr_q;
  assign done      = done_q;

  assign pop  = out_valid & out_ready;
  assign push = pending_q;

  // Slots committed after this edge: stored words plus the read landing now, minus the word leaving.
  // pop implies fifo_cnt_q >= 1, so the subtraction cannot underflow.
  assign occ   = fifo_cnt_q + CW'(pending_q) - CW'(pop);
  assign issue = (state_q == S_RUN) && (remain_q != '0) && (occ < CW'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    pending_d   = issue;
    last_pend_d = last_pend_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_base;
          remain_d = cmd_count;
          if (cmd_count != '0) state_d = S_RUN;
          else                 done_d  = 1'b1;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d      = addr_q + ADDR'(1);  // wraps naturally at 2**ADDR
          remain_d    = remain_q - (ADDR+1)'(1);
          last_pend_d = (remain_q == (ADDR+1)'(1));
        end
        if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      pending_q   <= 1'b0;
      last_pend_q <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      pending_q   <= pending_d;
      last_pend_q <= last_pend_d;
      done_q      <= done_d;
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; it is only observed while fifo_cnt_q says it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dat_q[wr_ptr_q]  <= bram_dout;
      fifo_last_q[wr_ptr_q] <= last_pend_q;
    end
  end

endmodule
